regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
Shares the single register-file write port (addr_rd / data_rd / write_enable) between two writeback requesters: req0 = ALU/execute writeback, req1 = load-return path. Round-robin arbitration with a valid/ready handshake and a registered output stage that drives the register file directly. Also provides a one-entry forwarding lookup for the write in flight, and a saturating conflict counter for performance debug.

Parameters:
DATA_WIDTH, 32, width of write data
ADDR_WIDTH, 5, register address width (32 architectural registers)
CNT_WIDTH, 16, width of the conflict counter

Ports:
clock  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
arb_enable  input  1  1 = arbitration allowed; 0 = no grants
req0_valid  input  1  requester 0 has a write
req0_addr  input  ADDR_WIDTH  requester 0 destination register
req0_data  input  DATA_WIDTH  requester 0 write data
req0_ready  output  1  grant to requester 0 (combinational)
req1_valid  input  1  requester 1 has a write
req1_addr  input  ADDR_WIDTH  requester 1 destination register
req1_data  input  DATA_WIDTH  requester 1 write data
req1_ready  output  1  grant to requester 1 (combinational)
write_enable  output  1  registered write strobe to register file
addr_rd  output  ADDR_WIDTH  registered destination address
data_rd  output  DATA_WIDTH  registered write data
fwd_addr  input  ADDR_WIDTH  forwarding lookup address
fwd_hit  output  1  in-flight write targets fwd_addr (combinational)
fwd_data  output  DATA_WIDTH  data_rd when fwd_hit, else 0
conflict_count  output  CNT_WIDTH  saturating count of cycles with both valid and arb_enable=1

Behaviour:
- Reset (async, reset_n=0): write_enable=0, addr_rd=0, data_rd=0, conflict_count=0, round-robin pointer last_grant=1 (req0 wins first tie). Outputs are cleared immediately, not at the next edge.
- Grant (combinational, same cycle):
  - arb_enable=0: both ready=0.
  - Only one valid: that requester gets ready=1.
  - Both valid: grant goes to the requester not in last_grant.
  - At most one ready is high per cycle.
  - Ready never asserts without the matching valid.
- Transfer occurs when valid && ready. A requester holds valid/addr/data stable until ready; the arbiter relies on this.
- Output stage, at the next edge after a transfer:
  - addr_rd and data_rd load the granted request.
  - write_enable = 1 if the granted addr != 0, else 0.
- No transfer: write_enable <= 0; addr_rd and data_rd hold their values.
- Latency: request accepted in cycle N; register file write strobe visible in cycle N+1. Throughput is one write per cycle, with no bubbles between back-to-back transfers.
- last_grant updates only on a transfer, to the granted index. It holds otherwise, including while arb_enable=0.
- x0 writes: accepted (ready=1, handshake completes) but produce write_enable=0. They still update last_grant.
- Same-address collision (both valid, equal addr): the winner writes in N+1, the loser in N+2. The loser's value is final. Write ordering between requesters is the pipeline's responsibility, not the arbiter's.
- Forwarding:
  - fwd_hit = write_enable && (addr_rd == fwd_addr) && (fwd_addr != 0).
  - fwd_data = data_rd when hit, else 0.
  - Covers the cycle in which the register file has not yet committed the write.
- conflict_count: increments on each edge where req0_valid && req1_valid && arb_enable. Saturates at all-ones; it does not wrap. It is cleared only by reset.
- Reset mid-operation: an in-flight output write is dropped (write_enable forced 0). Requests with ready=1 in the reset cycle are not considered accepted, because the ready outputs are forced 0 during reset.
- arb_enable falling with a pending output: the already-registered write still issues in the next cycle, then write_enable=0.

Test Plan:
- Reset release, req0_valid=1 addr=5 data=0xDEADBEEF -> req0_ready=1 same cycle; next cycle write_enable=1, addr_rd=5, data_rd=0xDEADBEEF; following idle cycle write_enable=0, addr_rd remains 5.
- Both valid continuously (req0 addr=3 data=0x11, req1 addr=4 data=0x22), each dropping valid after grant -> first grant req0 then req1; write_enable high two consecutive cycles; conflict_count=1.
- Both valid, held valid for 6 cycles -> grants alternate 0,1,0,1,0,1; conflict_count=6.
- Force conflict_count to saturate with CNT_WIDTH=4 (20 conflict cycles) -> stays at 15.
- req1_valid addr=0 data=0x55 -> req1_ready=1, write_enable stays 0, fwd_hit=0 for fwd_addr=0; next tie then grants req0.
- Transfer addr=7 data=0xA5A5A5A5 with fwd_addr=7 -> fwd_hit=1 and fwd_data=0xA5A5A5A5 in the write cycle. Then assert reset_n=0 mid-cycle -> write_enable, data_rd and fwd_hit go 0 immediately.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU
// writeback (req0) and the load-return path (req1), with a registered write stage.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  arb_enable,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] addr_rd,
    output logic [DATA_WIDTH-1:0] data_rd,
    input  logic [ADDR_WIDTH-1:0] fwd_addr,
    output logic                  fwd_hit,
    output logic [DATA_WIDTH-1:0] fwd_data,
    output logic [CNT_WIDTH-1:0]  conflict_count
);

    logic                  last_grant_reg;
    logic                  write_enable_reg;
    logic [ADDR_WIDTH-1:0] addr_rd_reg;
    logic [DATA_WIDTH-1:0] data_rd_reg;
    logic [CNT_WIDTH-1:0]  conflict_count_reg;

    logic                  grant0;
    logic                  grant1;
    logic                  transfer;
    logic                  conflict;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    // Gating with reset_n keeps a handshake from completing while reset is held.
    assign grant0 = reset_n && arb_enable && req0_valid && (!req1_valid || last_grant_reg);
    assign grant1 = reset_n && arb_enable && req1_valid && (!req0_valid || !last_grant_reg);

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign transfer   = grant0 || grant1;
    assign conflict   = req0_valid && req1_valid && arb_enable;
    assign sel_addr   = grant1 ? req1_addr : req0_addr;
    assign sel_data   = grant1 ? req1_data : req0_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_reg     <= 1'b1;
            write_enable_reg   <= 1'b0;
            addr_rd_reg        <= '0;
            data_rd_reg        <= '0;
            conflict_count_reg <= '0;
        end else begin
            if (transfer) begin
                addr_rd_reg      <= sel_addr;
                data_rd_reg      <= sel_data;
                // x0 is hardwired zero: the handshake completes but nothing is written.
                write_enable_reg <= (sel_addr != '0);
                last_grant_reg   <= grant1;
            end else begin
                write_enable_reg <= 1'b0;
            end
            if (conflict && (conflict_count_reg != '1)) begin
                conflict_count_reg <= conflict_count_reg + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign write_enable   = write_enable_reg;
    assign addr_rd        = addr_rd_reg;
    assign data_rd        = data_rd_reg;
    assign conflict_count = conflict_count_reg;

    // Bypass for the one cycle where the register file has not yet committed the write.
    assign fwd_hit  = write_enable_reg && (addr_rd_reg == fwd_addr) && (fwd_addr != '0);
    assign fwd_data = fwd_hit ? data_rd_reg : '0;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: stimulus queues expected grants and
// writes, a negedge monitor pops and compares them when the DUT presents them.
module tb_regfile_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          arb_enable;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          write_enable;
    logic [AW-1:0] addr_rd;
    logic [DW-1:0] data_rd;
    logic [AW-1:0] fwd_addr;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic [CW-1:0] conflict_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    int                 grant_q[$];
    logic [AW+DW-1:0]   write_q[$];

    regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset_n(reset_n), .arb_enable(arb_enable),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .write_enable(write_enable), .addr_rd(addr_rd), .data_rd(data_rd),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .conflict_count(conflict_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
            $display("ok   %s act=%0h exp=%0h", name, act, exp);
        end else begin
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Monitor: one line per presented grant / write strobe.
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            if (req0_ready && req1_ready) chk("both_ready", 64'd1, 64'd0);
            if (req0_ready || req1_ready) begin
                if (grant_q.size() == 0) chk("unexpected_grant", {63'd0, req1_ready}, 64'hFF);
                else chk("grant_idx", {63'd0, req1_ready}, 64'(grant_q.pop_front()));
            end
            if (write_enable) begin
                if (write_q.size() == 0) chk("unexpected_write", {27'd0, addr_rd, data_rd}, 64'hFFFF_FFFF_FFFF_FFFF);
                else chk("write_addr_data", {27'd0, addr_rd, data_rd}, {27'd0, write_q.pop_front()});
            end
        end
    end

    // Drive one cycle of requests (called at posedge+1), queue expectations, advance.
    task automatic step(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input int eg, input bit pw);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        if (eg == 0) begin
            grant_q.push_back(0);
            if (pw && a0 != '0) write_q.push_back({a0, d0});
        end else if (eg == 1) begin
            grant_q.push_back(1);
            if (pw && a1 != '0) write_q.push_back({a1, d1});
        end
        @(posedge clock); #1;
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0, -1, 1'b0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd2; req0_data = 32'h1;
        req1_valid = 1'b1; req1_addr = 5'd3; req1_data = 32'h2;
        arb_enable = 1'b1;
        #1;
        chk("rst_we", {63'd0, write_enable}, 64'd0);
        chk("rst_addr", {59'd0, addr_rd}, 64'd0);
        chk("rst_data", {32'd0, data_rd}, 64'd0);
        chk("rst_cnt", {60'd0, conflict_count}, 64'd0);
        chk("rst_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        fwd_addr = '0;
        req0_addr = '0; req0_data = '0; req1_addr = '0; req1_data = '0;
        do_reset();

        // Single write, then idle: strobe drops, address holds.
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 0, 1'b1);
        idle();
        chk("t1_we_idle", {63'd0, write_enable}, 64'd0);
        chk("t1_addr_hold", {59'd0, addr_rd}, 64'd5);
        chk("t1_data_hold", {32'd0, data_rd}, 64'hDEADBEEF);

        // Tie, each side drops after grant.
        do_reset();
        step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 0, 1'b1);
        chk("t2_we_first", {63'd0, write_enable}, 64'd1);
        step(1'b0, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1, 1'b1);
        chk("t2_we_second", {63'd0, write_enable}, 64'd1);
        chk("t2_cnt", {60'd0, conflict_count}, 64'd1);
        idle();

        // Sustained tie: alternating grants, then saturation of the 4-bit counter.
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, i % 2, 1'b1);
        chk("t3_cnt6", {60'd0, conflict_count}, 64'd6);
        for (int i = 6; i < 26; i++) step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, i % 2, 1'b1);
        chk("t4_cnt_sat", {60'd0, conflict_count}, 64'd15);
        idle();
        chk("t4_cnt_hold", {60'd0, conflict_count}, 64'd15);

        // x0 write from req1 still moves the pointer; arb_enable=0 blocks grants.
        do_reset();
        step(1'b1, 5'd9, 32'h99, 1'b0, '0, '0, 0, 1'b1);
        idle();
        step(1'b0, '0, '0, 1'b1, 5'd0, 32'h55, 1, 1'b1);
        idle();
        chk("t5_x0_we", {63'd0, write_enable}, 64'd0);
        chk("t5_x0_fwd", {63'd0, fwd_hit}, 64'd0);
        arb_enable = 1'b0;
        step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, -1, 1'b0);
        chk("t5_dis_cnt", {60'd0, conflict_count}, 64'd0);
        chk("t5_dis_we", {63'd0, write_enable}, 64'd0);
        arb_enable = 1'b1;
        step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 0, 1'b1);
        step(1'b0, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1, 1'b1);
        idle();
        chk("t5_cnt", {60'd0, conflict_count}, 64'd1);

        // Forwarding hit/miss, then asynchronous reset during the write cycle.
        fwd_addr = 5'd7;
        step(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, '0, '0, 0, 1'b0);
        chk("t6_we", {63'd0, write_enable}, 64'd1);
        chk("t6_fwd_hit", {63'd0, fwd_hit}, 64'd1);
        chk("t6_fwd_data", {32'd0, fwd_data}, 64'hA5A5A5A5);
        fwd_addr = 5'd8;
        #1;
        chk("t6_fwd_miss", {63'd0, fwd_hit}, 64'd0);
        chk("t6_fwd_miss_data", {32'd0, fwd_data}, 64'd0);
        fwd_addr = 5'd7;
        req0_valid = 1'b1; req0_addr = 5'd6; req0_data = 32'h66;
        #1;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_we", {63'd0, write_enable}, 64'd0);
        chk("t6_rst_data", {32'd0, data_rd}, 64'd0);
        chk("t6_rst_fwd", {63'd0, fwd_hit}, 64'd0);
        chk("t6_rst_ready", {63'd0, req0_ready}, 64'd0);
        @(posedge clock); #1;
        req0_valid = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        idle();
        chk("t6_no_stale_write", {63'd0, write_enable}, 64'd0);
        idle();

        chk("grant_q_empty", 64'(grant_q.size()), 64'd0);
        chk("write_q_empty", 64'(write_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
